// File: rtl/cplx_matmul_pkg.sv
// Shared definitions for the complex matrix-multiply engine.
// Holds the controller state enum, the clog2 and accumulator-width helpers,
// and pack/unpack helpers for {real, imag} complex elements.
// The optional CPLX_MATMUL_SAT_EN macro is consumed by cplx_matmul_engine.
package cplx_matmul_pkg;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_MAC  = 2'd1,
    ST_EMIT = 2'd2
  } state_t;

  // Widest component the pack/unpack helpers can carry.
  localparam int MAX_CW = 64;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

  // Full-precision width of one accumulated component: product + add + N terms.
  function automatic int acc_width(input int w, input int n);
    return 2 * w + 1 + clog2(n);
  endfunction

  // Sign-extended real half of a packed element whose components are cw bits.
  function automatic logic signed [MAX_CW-1:0] cplx_re(input logic [2*MAX_CW-1:0] e,
                                                       input int cw);
    logic signed [MAX_CW-1:0] s;
    s = $signed(MAX_CW'(e >> cw));
    s = s <<< (MAX_CW - cw);
    return s >>> (MAX_CW - cw);
  endfunction

  // Sign-extended imaginary half of a packed element whose components are cw bits.
  function automatic logic signed [MAX_CW-1:0] cplx_im(input logic [2*MAX_CW-1:0] e,
                                                       input int cw);
    logic signed [MAX_CW-1:0] s;
    s = $signed(MAX_CW'(e));
    s = s <<< (MAX_CW - cw);
    return s >>> (MAX_CW - cw);
  endfunction

  // Packs the low cw bits of each component as {real, imag}.
  function automatic logic [2*MAX_CW-1:0] cplx_pack(input logic [MAX_CW-1:0] re,
                                                    input logic [MAX_CW-1:0] im,
                                                    input int cw);
    logic [2*MAX_CW-1:0] m;
    logic [2*MAX_CW-1:0] r;
    m = {(2*MAX_CW){1'b1}} >> (2 * MAX_CW - cw);
    r = (({{MAX_CW{1'b0}}, re} & m) << cw) | ({{MAX_CW{1'b0}}, im} & m);
    return r;
  endfunction

endpackage

// File: rtl/cplx_matmul_engine_mac.sv
// Signed complex multiply-accumulate with clear (module cplx_mac).
// o_sum_* is the value the accumulator takes at the next enabled edge, so the
// caller can register a finished dot product in the same cycle it completes.
module cplx_mac
  import cplx_matmul_pkg::*;
#(
  parameter int W  = 8,
  parameter int AW = 19
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_en,
  input  logic                 i_clr,
  input  logic signed [W-1:0]  i_a_re,
  input  logic signed [W-1:0]  i_a_im,
  input  logic signed [W-1:0]  i_b_re,
  input  logic signed [W-1:0]  i_b_im,
  output logic signed [AW-1:0] o_sum_re,
  output logic signed [AW-1:0] o_sum_im
);

  logic signed [AW-1:0]  r_acc_re;
  logic signed [AW-1:0]  r_acc_im;
  logic signed [2*W-1:0] w_ac;
  logic signed [2*W-1:0] w_bd;
  logic signed [2*W-1:0] w_ad;
  logic signed [2*W-1:0] w_bc;
  logic signed [AW-1:0]  w_term_re;
  logic signed [AW-1:0]  w_term_im;
  logic signed [AW-1:0]  w_base_re;
  logic signed [AW-1:0]  w_base_im;

  // (a+jb)(c+jd) = (ac-bd) + j(ad+bc), added to the accumulator or to zero on clear.
  always_comb begin
    w_ac      = i_a_re * i_b_re;
    w_bd      = i_a_im * i_b_im;
    w_ad      = i_a_re * i_b_im;
    w_bc      = i_a_im * i_b_re;
    w_term_re = {{(AW-2*W){w_ac[2*W-1]}}, w_ac} - {{(AW-2*W){w_bd[2*W-1]}}, w_bd};
    w_term_im = {{(AW-2*W){w_ad[2*W-1]}}, w_ad} + {{(AW-2*W){w_bc[2*W-1]}}, w_bc};
    w_base_re = i_clr ? '0 : r_acc_re;
    w_base_im = i_clr ? '0 : r_acc_im;
    o_sum_re  = w_base_re + w_term_re;
    o_sum_im  = w_base_im + w_term_im;
  end

  // Accumulator register, advanced only on MAC cycles.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_acc_re <= '0;
      r_acc_im <= '0;
    end else if (i_en) begin
      r_acc_re <= o_sum_re;
      r_acc_im <= o_sum_im;
    end
  end

endmodule

// File: rtl/cplx_matmul_engine.sv
// Complex N x N matrix multiply engine: C = A x B.
// LOAD streams A/B pairs row-major, MAC spends N cycles per result element,
// EMIT holds one result until the downstream handshake.
// Define CPLX_MATMUL_SAT_EN to saturate outputs to OW bits and report Ovf;
// otherwise outputs wrap to OW bits and Ovf stays 0.
module cplx_matmul_engine
  import cplx_matmul_pkg::*;
#(
  parameter int N  = 3,
  parameter int W  = 8,
  parameter int OW = 2 * W + 1 + clog2(N)
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic [2*W-1:0]  i_in_a,
  input  logic [2*W-1:0]  i_in_b,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [2*OW-1:0] o_out_data,
  output logic            o_busy,
  output logic            o_ovf
);

  localparam int AW = acc_width(W, N);
  localparam int IW = clog2(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_t              r_state;
  logic [IW-1:0]       r_li;
  logic [IW-1:0]       r_lj;
  logic [IW-1:0]       r_i;
  logic [IW-1:0]       r_j;
  logic [IW-1:0]       r_k;
  logic [2*W-1:0]      r_a [N][N];
  logic [2*W-1:0]      r_b [N][N];
  logic                r_in_ready;
  logic                r_out_valid;
  logic                r_busy;
  logic                r_ovf;
  logic [2*OW-1:0]     r_out_data;

  logic [2*W-1:0]      w_a_elem;
  logic [2*W-1:0]      w_b_elem;
  logic signed [W-1:0] w_a_re;
  logic signed [W-1:0] w_a_im;
  logic signed [W-1:0] w_b_re;
  logic signed [W-1:0] w_b_im;
  logic                w_mac_en;
  logic                w_mac_clr;
  logic signed [AW-1:0] w_sum_re;
  logic signed [AW-1:0] w_sum_im;
  logic [OW-1:0]       w_re_o;
  logic [OW-1:0]       w_im_o;
  logic                w_ovf_now;
  logic [2*OW-1:0]     w_pack;

`ifdef CPLX_MATMUL_SAT_EN
  localparam logic signed [AW-1:0] OMAX = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [AW-1:0] OMIN = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};
`endif

  // Operand fetch for the current dot-product step: A[i][k] and B[k][j].
  always_comb begin
    w_a_elem  = r_a[r_i][r_k];
    w_b_elem  = r_b[r_k][r_j];
    w_a_re    = W'(cplx_re({{(2*MAX_CW-2*W){1'b0}}, w_a_elem}, W));
    w_a_im    = W'(cplx_im({{(2*MAX_CW-2*W){1'b0}}, w_a_elem}, W));
    w_b_re    = W'(cplx_re({{(2*MAX_CW-2*W){1'b0}}, w_b_elem}, W));
    w_b_im    = W'(cplx_im({{(2*MAX_CW-2*W){1'b0}}, w_b_elem}, W));
    w_mac_en  = (r_state == ST_MAC);
    w_mac_clr = (r_k == '0);
  end

  cplx_mac #(
    .W  (W),
    .AW (AW)
  ) u_mac (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_en     (w_mac_en),
    .i_clr    (w_mac_clr),
    .i_a_re   (w_a_re),
    .i_a_im   (w_a_im),
    .i_b_re   (w_b_re),
    .i_b_im   (w_b_im),
    .o_sum_re (w_sum_re),
    .o_sum_im (w_sum_im)
  );

  // Reduce the full-width sum to OW bits: saturate when enabled, else wrap.
  always_comb begin
    w_re_o    = OW'(w_sum_re);
    w_im_o    = OW'(w_sum_im);
    w_ovf_now = 1'b0;
`ifdef CPLX_MATMUL_SAT_EN
    if (w_sum_re > OMAX) begin
      w_re_o    = OW'(OMAX);
      w_ovf_now = 1'b1;
    end else if (w_sum_re < OMIN) begin
      w_re_o    = OW'(OMIN);
      w_ovf_now = 1'b1;
    end
    if (w_sum_im > OMAX) begin
      w_im_o    = OW'(OMAX);
      w_ovf_now = 1'b1;
    end else if (w_sum_im < OMIN) begin
      w_im_o    = OW'(OMIN);
      w_ovf_now = 1'b1;
    end
`endif
    w_pack = (2*OW)'(cplx_pack(MAX_CW'(w_re_o), MAX_CW'(w_im_o), OW));
  end

  // Matrix storage written by accepted LOAD beats; stale contents are always
  // fully overwritten by the next complete load, so no reset is needed.
  always_ff @(posedge i_clk) begin
    if (!i_reset && r_state == ST_LOAD && i_in_valid) begin
      r_a[r_li][r_lj] <= i_in_a;
      r_b[r_li][r_lj] <= i_in_b;
    end
  end

  // Controller: LOAD -> MAC (N cycles) -> EMIT -> MAC ... -> LOAD, with registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_LOAD;
      r_li        <= '0;
      r_lj        <= '0;
      r_i         <= '0;
      r_j         <= '0;
      r_k         <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_busy      <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (i_in_valid) begin
            if (r_lj == LAST) begin
              r_lj <= '0;
              if (r_li == LAST) begin
                r_li       <= '0;
                r_i        <= '0;
                r_j        <= '0;
                r_k        <= '0;
                r_ovf      <= 1'b0;
                r_in_ready <= 1'b0;
                r_busy     <= 1'b1;
                r_state    <= ST_MAC;
              end else begin
                r_li <= r_li + 1'b1;
              end
            end else begin
              r_lj <= r_lj + 1'b1;
            end
          end
        end
        ST_MAC: begin
          if (r_k == LAST) begin
            r_k         <= '0;
            r_out_valid <= 1'b1;
            r_out_data  <= w_pack;
            r_ovf       <= r_ovf | w_ovf_now;
            r_state     <= ST_EMIT;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        ST_EMIT: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            if (r_j == LAST) begin
              r_j <= '0;
              if (r_i == LAST) begin
                r_i        <= '0;
                r_in_ready <= 1'b1;
                r_busy     <= 1'b0;
                r_state    <= ST_LOAD;
              end else begin
                r_i     <= r_i + 1'b1;
                r_state <= ST_MAC;
              end
            end else begin
              r_j     <= r_j + 1'b1;
              r_state <= ST_MAC;
            end
          end
        end
        default: begin
          r_state <= ST_LOAD;
        end
      endcase
    end
  end

  // In the wrapping build w_ovf_now is constant 0, so Ovf is tied low.
  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_busy      = r_busy;
  assign o_ovf       = r_ovf;

endmodule

// File: tb/tb_cplx_matmul_engine.sv
// Self-checking bench for cplx_matmul_engine (N=3, W=8, OW=16).
// Table of matrix cases plus hand-written reset sequences; expected results
// are queued when a load starts and popped as the engine emits them.
module tb_cplx_matmul_engine;

  localparam int N  = 3;
  localparam int W  = 8;
  localparam int OW = 16;

  logic            i_clk;
  logic            i_reset;
  logic            i_in_valid;
  logic            o_in_ready;
  logic [2*W-1:0]  i_in_a;
  logic [2*W-1:0]  i_in_b;
  logic            o_out_valid;
  logic            i_out_ready;
  logic [2*OW-1:0] o_out_data;
  logic            o_busy;
  logic            o_ovf;

  int checks;
  int errors;
  logic [31:0] sbQ[$];

  typedef struct packed {
    logic [8:0][15:0] a;
    logic [8:0][15:0] b;
    logic [8:0][31:0] c;
    logic             ovf;
    logic             gap;
    int               stallElem;
  } vec_t;

  vec_t vecs[4];

  cplx_matmul_engine #(
    .N  (N),
    .W  (W),
    .OW (OW)
  ) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_in_a      (i_in_a),
    .i_in_b      (i_in_b),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_out_data  (o_out_data),
    .o_busy      (o_busy),
    .o_ovf       (o_ovf)
  );

  // Free-running clock.
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Hard stop in case something hangs outside the bounded waits.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Reduce one component to OW=16 bits the way the configured build should.
  function automatic logic [16:0] reduceComp(input longint v);
    logic [16:0] r;
`ifdef CPLX_MATMUL_SAT_EN
    if (v > 32767) r = {1'b1, 16'h7FFF};
    else if (v < -32768) r = {1'b1, 16'h8000};
    else r = {1'b0, v[15:0]};
`else
    r = {1'b0, v[15:0]};
`endif
    return r;
  endfunction

  // Reference complex matrix product with integer arithmetic.
  function automatic void modelMatmul(input logic [8:0][15:0] a, input logic [8:0][15:0] b,
                                      output logic [8:0][31:0] c, output logic ovf);
    logic signed [7:0] ar, ai, br, bi;
    logic [16:0] rr, ri;
    longint re, im;
    ovf = 1'b0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        re = 0;
        im = 0;
        for (int k = 0; k < N; k++) begin
          ar = a[i*N+k][15:8];
          ai = a[i*N+k][7:0];
          br = b[k*N+j][15:8];
          bi = b[k*N+j][7:0];
          re = re + ar * br - ai * bi;
          im = im + ar * bi + ai * br;
        end
        rr = reduceComp(re);
        ri = reduceComp(im);
        c[i*N+j] = {rr[15:0], ri[15:0]};
        ovf = ovf | rr[16] | ri[16];
      end
    end
  endfunction

  task automatic pushExpected(input logic [8:0][31:0] c);
    for (int t = 0; t < N * N; t++) sbQ.push_back(c[t]);
  endtask

  // Streams nBeats element pairs; with gap set, In_Valid toggles every cycle.
  task automatic applyStimulus(input logic [8:0][15:0] a, input logic [8:0][15:0] b,
                               input logic gap, input int nBeats);
    int t;
    int cyc;
    logic vld;
    logic rdy;
    t = 0;
    cyc = 0;
    while (t < nBeats && cyc < 100) begin
      vld = gap ? ~cyc[0] : 1'b1;
      i_in_valid = vld;
      i_in_a = vld ? a[t] : 16'($urandom);
      i_in_b = vld ? b[t] : 16'($urandom);
      rdy = o_in_ready;
      @(posedge i_clk);
      #1;
      if (vld && rdy) t++;
      cyc++;
    end
    i_in_valid = 1'b0;
    if (t < nBeats) checkOutput("load_timeout_beats", t, nBeats);
  endtask

  // Collects 9 results, checking spacing, optional stall hold, and end state.
  task automatic drainOutputs(input string tag, input int stallElem, input logic expOvf);
    int got;
    int idle;
    int total;
    logic [31:0] exp;
    got = 0;
    idle = 0;
    total = 0;
    i_out_ready = 1'b1;
    i_in_valid = 1'b1;
    i_in_a = 16'h7F7F;
    i_in_b = 16'h8181;
    while (got < N * N && total < 300) begin
      if (o_out_valid) begin
        checkOutput($sformatf("%s_idle_before_%0d", tag, got), idle, N);
        if (got == stallElem) begin
          i_out_ready = 1'b0;
          for (int s = 0; s < 5; s++) begin
            @(posedge i_clk);
            #1;
            checkOutput($sformatf("%s_stall_valid", tag), o_out_valid, 1);
            checkOutput($sformatf("%s_stall_inready", tag), o_in_ready, 0);
            checkOutput($sformatf("%s_stall_busy", tag), o_busy, 1);
            if (sbQ.size() > 0) checkOutput($sformatf("%s_stall_data", tag), o_out_data, sbQ[0]);
          end
          i_out_ready = 1'b1;
        end
        if (sbQ.size() == 0) begin
          checkOutput($sformatf("%s_unexpected_output_%0d", tag, got), o_out_data, 32'hDEAD_BEEF);
        end else begin
          exp = sbQ.pop_front();
          checkOutput($sformatf("%s_elem_%0d", tag, got), o_out_data, exp);
        end
        got++;
        idle = 0;
      end else begin
        idle++;
      end
      @(posedge i_clk);
      #1;
      total++;
    end
    i_in_valid = 1'b0;
    if (got < N * N) checkOutput($sformatf("%s_output_timeout", tag), got, N * N);
    checkOutput($sformatf("%s_end_valid", tag), o_out_valid, 0);
    checkOutput($sformatf("%s_end_inready", tag), o_in_ready, 1);
    checkOutput($sformatf("%s_end_busy", tag), o_busy, 0);
    checkOutput($sformatf("%s_end_ovf", tag), o_ovf, expOvf);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput($sformatf("%s_valid", tag), o_out_valid, 0);
    checkOutput($sformatf("%s_data", tag), o_out_data, 0);
    checkOutput($sformatf("%s_busy", tag), o_busy, 0);
    checkOutput($sformatf("%s_inready", tag), o_in_ready, 1);
    checkOutput($sformatf("%s_ovf", tag), o_ovf, 0);
  endtask

  initial begin
    int w;
    logic [31:0] satImag;
    logic satOvf;
    checks = 0;
    errors = 0;
    i_reset = 1'b1;
    i_in_valid = 1'b0;
    i_in_a = '0;
    i_in_b = '0;
    i_out_ready = 1'b1;

`ifdef CPLX_MATMUL_SAT_EN
    satImag = 32'd32767;
    satOvf = 1'b1;
`else
    satImag = 32'd31238;
    satOvf = 1'b0;
`endif

    // Case 0: identity A, B[t] = t - jt, so C equals B.
    for (int t = 0; t < 9; t++) begin
      vecs[0].a[t] = (t % 4 == 0) ? 16'h0100 : 16'h0000;
      vecs[0].b[t] = {8'(t), 8'(-t)};
      vecs[0].c[t] = {16'(t), 16'(-t)};
    end
    vecs[0].ovf = 1'b0;
    vecs[0].gap = 1'b0;
    vecs[0].stallElem = -1;

    // Case 1: (1+j1)(1-j1) = 2, summed three times -> 6+j0; stall on (1,1).
    for (int t = 0; t < 9; t++) begin
      vecs[1].a[t] = 16'h0101;
      vecs[1].b[t] = 16'h01FF;
      vecs[1].c[t] = {16'd6, 16'd0};
    end
    vecs[1].ovf = 1'b0;
    vecs[1].gap = 1'b0;
    vecs[1].stallElem = 4;

    // Case 2: all 127+j127 -> real 0, imag 96774 (saturated or wrapped); gapped load.
    for (int t = 0; t < 9; t++) begin
      vecs[2].a[t] = 16'h7F7F;
      vecs[2].b[t] = 16'h7F7F;
      vecs[2].c[t] = {16'd0, satImag[15:0]};
    end
    vecs[2].ovf = satOvf;
    vecs[2].gap = 1'b1;
    vecs[2].stallElem = -1;

    // Case 3: random operands checked against the reference model.
    for (int t = 0; t < 9; t++) begin
      vecs[3].a[t] = 16'($urandom);
      vecs[3].b[t] = 16'($urandom);
    end
    modelMatmul(vecs[3].a, vecs[3].b, vecs[3].c, vecs[3].ovf);
    vecs[3].gap = 1'b0;
    vecs[3].stallElem = 2;

    repeat (2) @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    checkResetState("reset_init");

    for (int v = 0; v < 4; v++) begin
      $display("[TB] running table case %0d", v);
      pushExpected(vecs[v].c);
      applyStimulus(vecs[v].a, vecs[v].b, vecs[v].gap, 9);
      checkOutput($sformatf("case%0d_inready_after_load", v), o_in_ready, 0);
      checkOutput($sformatf("case%0d_busy_after_load", v), o_busy, 1);
      drainOutputs($sformatf("case%0d", v), vecs[v].stallElem, vecs[v].ovf);
    end

    // Reset while the first result is being offered, with a handshake pending.
    $display("[TB] reset during EMIT");
    applyStimulus(vecs[2].a, vecs[2].b, 1'b0, 9);
    w = 0;
    i_out_ready = 1'b0;
    while (!o_out_valid && w < 50) begin
      @(posedge i_clk);
      #1;
      w++;
    end
    checkOutput("emit_reached", o_out_valid, 1);
    checkOutput("emit_ovf_before_reset", o_ovf, satOvf);
    i_out_ready = 1'b1;
    i_reset = 1'b1;
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    checkResetState("reset_emit");

    // Reset after four beats; only the following full load may matter.
    $display("[TB] reset during LOAD");
    applyStimulus(vecs[3].a, vecs[3].b, 1'b0, 4);
    i_reset = 1'b1;
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    checkResetState("reset_load");
    pushExpected(vecs[0].c);
    applyStimulus(vecs[0].a, vecs[0].b, 1'b0, 9);
    drainOutputs("after_load_reset", -1, 1'b0);

    checkOutput("scoreboard_empty", sbQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cplx_matmul_engine.md
CPLX_MATMUL_ENGINE -- requirements
Module: cplx_matmul_engine

Interface
REQ-001 Parameter N, default 3, square matrix dimension (N >= 2).
REQ-002 Parameter W, default 8, signed component width; an element is 2W bits packed {real, imag}, real in the upper half.
REQ-003 Parameter OW, default 2W+1+clog2(N), output component width (OW <= 2W+1+clog2(N)).
REQ-004 Clk  input  1  single clock; all logic on the rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 In_Valid  input  1  In_A/In_B carry one element pair.
REQ-007 In_Ready  output  1  engine accepts an element pair this cycle.
REQ-008 In_A  input  2W  element of matrix A.
REQ-009 In_B  input  2W  element of matrix B.
REQ-010 Out_Valid  output  1  Out_Data holds one result element.
REQ-011 Out_Ready  input  1  downstream accepts Out_Data.
REQ-012 Out_Data  output  2*OW  result element {real, imag}.
REQ-013 Busy  output  1  high in MAC or EMIT.
REQ-014 Ovf  output  1  sticky overflow flag for the current result matrix.

Function
REQ-015 The engine SHALL compute C = A x B over complex numbers, with C[i][j] = sum over k of A[i][k]*B[k][j].
- States: LOAD, MAC, EMIT.
REQ-016 In LOAD, In_Ready SHALL be 1; each In_Valid&&In_Ready beat t (0..N*N-1) writes A[i][j] and B[i][j], with i=t/N and j=t%N, in row-major order.
REQ-017 After beat N*N-1 is accepted, the engine SHALL enter MAC for element (0,0) on the next cycle; In_Ready SHALL be 0 outside LOAD.
REQ-018 MAC SHALL last exactly N cycles per element:
- the accumulator is cleared on entry;
- cycle k adds A[i][k]*B[k][j];
- real = ac-bd and imag = ad+bc, at full width 2W+1+clog2(N).
REQ-019 On the cycle after MAC k=N-1, the engine SHALL enter EMIT with Out_Valid=1 and Out_Data registered from the accumulator, reduced to OW bits per REQ-027/028.
REQ-020 Out_Data SHALL remain stable while Out_Valid=1 and Out_Ready=0.
REQ-021 On Out_Valid&&Out_Ready the engine SHALL:
- advance (i,j) in row-major order and re-enter MAC the next cycle;
- after element (N-1,N-1), return to LOAD with Out_Valid=0.
REQ-022 Minimum latency from last load beat to first Out_Valid SHALL be N+1 cycles; minimum time per element SHALL be N+1 cycles.
REQ-023 In_Valid outside LOAD SHALL be ignored with no state change.
REQ-024 Ovf SHALL clear on entry to MAC for element (0,0) and set when any element of the matrix overflows OW.

Reset
REQ-025 Reset SHALL, at any time including mid-LOAD or mid-EMIT:
- force LOAD, clear counters, accumulator and Ovf;
- drive Out_Valid=0, Out_Data=0, Busy=0, In_Ready=1 on the following cycle;
- discard partially loaded matrices.
REQ-026 Reset SHALL take priority over a simultaneous handshake.

Configuration
REQ-027 With CPLX_MATMUL_SAT_EN defined, each output component SHALL saturate to [-2^(OW-1), 2^(OW-1)-1], and overflow SHALL set Ovf.
REQ-028 Without CPLX_MATMUL_SAT_EN, each component SHALL wrap (keep the low OW bits), and Ovf SHALL be tied 0.

Structure
REQ-029 Package cplx_matmul_pkg SHALL hold:
- the state enum;
- the clog2 function;
- the accumulator-width constant expression;
- component pack/unpack helpers.
REQ-030 Sub-module cplx_mac SHALL implement one signed complex multiply-accumulate with clear; the top instantiates it once.

Verification
REQ-031 N=3, W=8; A = identity (1+j0 on the diagonal), B[t] = (t)+j(-t) -> C equals B, 9 outputs in row-major order, Ovf=0.
REQ-032 A all (1+j1), B all (1-j1) -> every output = 6+j0.
REQ-033 A and B all (127+j127), OW=16:
- with SAT_EN -> output {0, 32767}, Ovf=1;
- without SAT_EN -> imag = 96774 mod 2^16 = 31238, Ovf=0.
REQ-034 Out_Ready held low 5 cycles on element (1,1) -> Out_Data stable; next output after release is (1,2); In_Ready stays 0.
REQ-035 Reset asserted after 4 load beats, then a full 9-beat load -> results depend only on the second load.
REQ-036 In_Valid toggling every other cycle during LOAD -> exactly 9 beats accepted; first Out_Valid 4 cycles after the last accepted beat.
